// File: rtl/mips_mem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mips_mem_pkg                                                             |
// | Opcodes, FSM state encoding and small decode helpers shared by the       |
// | data-memory access unit and its lane aligner.                            |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package mips_mem_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    MERGE  = 2'd2
  } state_t;

  function automatic logic is_store(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  // Unsupported opcode, or an address not aligned to the access size.
  function automatic logic access_err(input logic [5:0] op, input logic [1:0] lo);
    logic e;
    case (op)
      OP_LB, OP_LBU, OP_SB: e = 1'b0;
      OP_LH, OP_LHU, OP_SH: e = lo[0];
      OP_LW, OP_SW:         e = |lo;
      default:              e = 1'b1;
    endcase
    return e;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_access_unit_if                                                       |
// | Request/response bundle from the execute stage plus the word-wide data   |
// | RAM port. "slave" is the access unit; "master" is everything around it.  |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
interface mem_access_unit_if;
  logic        req;
  logic [5:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_we;
  logic [31:0] ram_rdata;

  modport master (
    output req, op, addr, wdata, ram_rdata,
    input  busy, done, err, rdata, ram_addr, ram_wdata, ram_we
  );

  modport slave (
    input  req, op, addr, wdata, ram_rdata,
    output busy, done, err, rdata, ram_addr, ram_wdata, ram_we
  );
endinterface
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_lane_align                                                           |
// | Combinational little-endian lane handling: load extract/extend and       |
// | sub-word store merge into an existing RAM word.                          |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module mem_lane_align
  import mips_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  lane,
  input  logic [5:0]  op,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  function automatic logic [31:0] load_extract(input logic [31:0] w,
                                               input logic [1:0]  a,
                                               input logic [5:0]  o);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (o)
      OP_LB:   r = {{24{b[7]}}, b};
      OP_LBU:  r = {24'h0, b};
      OP_LH:   r = {{16{h[15]}}, h};
      OP_LHU:  r = {16'h0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] w,
                                              input logic [31:0] wd,
                                              input logic [1:0]  a,
                                              input logic [5:0]  o);
    logic [31:0] m;
    m = w;
    case (o)
      OP_SB: m[{a, 3'b000} +: 8] = wd[7:0];
      OP_SH: begin
        if (a[1]) m[31:16] = wd[15:0];
        else      m[15:0]  = wd[15:0];
      end
      default: m = wd;
    endcase
    return m;
  endfunction

  assign load_data = load_extract(word, lane, op);
  assign merged    = store_merge(word, wdata, lane, op);

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_access_unit                                                          |
// | One-at-a-time MIPS load/store initiator for a combinational-read data    |
// | RAM. Sub-word stores are done as read (ACCESS) then write (MERGE).       |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module mem_access_unit
  import mips_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  mem_access_unit_if.slave  bus
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [5:0]  r_op;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_merged;
  logic [31:0] r_rdata;
  logic        r_done;
  logic        r_err;

  logic        w_capture;
  logic        w_finish;
  logic        w_fin_err;
  logic        w_load_en;
  logic        w_merge_en;
  logic        w_ram_we;
  logic [31:0] w_ram_wdata;
  logic [31:0] w_load_data;
  logic [31:0] w_merged;
  logic        w_acc_err;

  assign w_acc_err = access_err(r_op, r_addr[1:0]);

  mem_lane_align u_align (
    .word      (bus.ram_rdata),
    .wdata     (r_wdata),
    .lane      (r_addr[1:0]),
    .op        (r_op),
    .load_data (w_load_data),
    .merged    (w_merged)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state, RAM strobes and datapath enables.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_finish    = 1'b0;
    w_fin_err   = 1'b0;
    w_load_en   = 1'b0;
    w_merge_en  = 1'b0;
    w_ram_we    = 1'b0;
    w_ram_wdata = 32'h0;
    case (r_state)
      IDLE: begin
        if (bus.req) begin
          w_capture   = 1'b1;
          w_state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        if (w_acc_err) begin
          w_finish    = 1'b1;
          w_fin_err   = 1'b1;
          w_state_nxt = IDLE;
        end else if (!is_store(r_op)) begin
          w_load_en   = 1'b1;
          w_finish    = 1'b1;
          w_state_nxt = IDLE;
        end else if (r_op == OP_SW) begin
          w_ram_we    = 1'b1;
          w_ram_wdata = r_wdata;
          w_finish    = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          // Sub-word store: the RAM word is being read now; keep the merge.
          w_merge_en  = 1'b1;
          w_state_nxt = MERGE;
        end
      end
      MERGE: begin
        w_ram_we    = 1'b1;
        w_ram_wdata = r_merged;
        w_finish    = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Captured request, merge buffer, load result and completion flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op     <= 6'h0;
      r_addr   <= 32'h0;
      r_wdata  <= 32'h0;
      r_merged <= 32'h0;
      r_rdata  <= 32'h0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= w_finish;
      r_err  <= w_fin_err;
      if (w_capture) begin
        r_op    <= bus.op;
        r_addr  <= bus.addr;
        r_wdata <= bus.wdata;
      end
      if (w_merge_en) r_merged <= w_merged;
      if (w_load_en)  r_rdata  <= w_load_data;
    end
  end

  assign bus.busy      = (r_state != IDLE);
  assign bus.done      = r_done;
  assign bus.err       = r_err;
  assign bus.rdata     = r_rdata;
  assign bus.ram_addr  = {r_addr[31:2], 2'b00};
  assign bus.ram_wdata = w_ram_wdata;
  // Reset must block a write even in the MERGE cycle.
  assign bus.ram_we    = w_ram_we & ~rst;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_access_unit                                                       |
// | Self-checking bench: directed load/store scenarios plus randomized       |
// | traffic compared against a byte-array memory model.                      |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_mem_access_unit;

  logic clk;
  logic rst;
  mem_access_unit_if bus ();

  mem_access_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 64-byte RAM behind the unit.
  logic [31:0] ram [0:15];
  logic [31:0] init_val [0:15];
  logic        load_ram;
  int          wr_count;

  assign bus.ram_rdata = ram[bus.ram_addr[5:2]];

  // RAM write port (preload during reset, then commits when ram_we is high).
  always @(posedge clk) begin
    if (load_ram) begin
      for (int i = 0; i < 16; i++) ram[i] <= init_val[i];
    end else if (bus.ram_we) begin
      ram[bus.ram_addr[5:2]] <= bus.ram_wdata;
      wr_count <= wr_count + 1;
    end
  end

  // Reference model: plain byte memory plus the last successful load value.
  logic [7:0]  ref_mem [0:63];
  logic [31:0] ref_rdata;

  int checks;
  int errors;

  logic        snap_we [0:3];
  logic [31:0] snap_wd [0:3];
  logic [31:0] snap_ad [0:3];

  function automatic int op_size(input logic [5:0] o);
    case (o)
      6'h20, 6'h24, 6'h28: return 1;
      6'h21, 6'h25, 6'h29: return 2;
      6'h23, 6'h2B:        return 4;
      default:             return 0;
    endcase
  endfunction

  task automatic ref_apply(input logic [5:0] o, input logic [31:0] a, input logic [31:0] d,
                           output logic e, output int lat, output int wr, output logic [31:0] rd);
    int   sz;
    bit   st;
    bit   sgn;
    logic [63:0] v;
    sz  = op_size(o);
    st  = (o == 6'h28) || (o == 6'h29) || (o == 6'h2B);
    sgn = (o == 6'h20) || (o == 6'h21);
    if (sz == 0 || (a % sz) != 0) begin
      e = 1'b1; lat = 1; wr = 0;
    end else if (st) begin
      for (int i = 0; i < sz; i++) ref_mem[a[5:0] + i] = d[8*i +: 8];
      e = 1'b0; lat = (sz == 4) ? 1 : 2; wr = 1;
    end else begin
      v = 64'h0;
      for (int i = 0; i < sz; i++) v[8*i +: 8] = ref_mem[a[5:0] + i];
      if (sgn && v[8*sz-1]) v = v | (~64'h0 << (8*sz));
      ref_rdata = v[31:0];
      e = 1'b0; lat = 1; wr = 0;
    end
    rd = ref_rdata;
  endtask

  // Drives one request starting at a negedge with busy=0; returns at the done negedge.
  task automatic do_op(input logic [5:0] o, input logic [31:0] a, input logic [31:0] d,
                       output int lat, output logic e, output logic acc_busy, output int wr_delta);
    int w0;
    int n;
    w0 = wr_count;
    for (int i = 0; i < 4; i++) begin snap_we[i] = 1'b0; snap_wd[i] = 32'h0; snap_ad[i] = 32'h0; end
    bus.req = 1'b1; bus.op = o; bus.addr = a; bus.wdata = d;
    @(posedge clk);
    #1 bus.req = 1'b0;
    lat = -1; e = 1'b0; acc_busy = 1'b0; n = 0;
    while (n < 8) begin
      @(negedge clk);
      if (n < 4) begin snap_we[n] = bus.ram_we; snap_wd[n] = bus.ram_wdata; snap_ad[n] = bus.ram_addr; end
      if (n == 0) acc_busy = bus.busy;
      if (bus.done) begin lat = n; e = bus.err; break; end
      n++;
    end
    wr_delta = wr_count - w0;
  endtask

  task automatic test_reset;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b exp 0", bus.done); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b exp 0", bus.err); end
    checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h exp 0", bus.rdata); end
    checks++; if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL reset_ram_we: got %b exp 0", bus.ram_we); end
    checks++; if (bus.ram_wdata !== 32'h0) begin errors++; $display("FAIL reset_ram_wdata: got %h exp 0", bus.ram_wdata); end
    checks++; if (bus.ram_addr !== 32'h0) begin errors++; $display("FAIL reset_ram_addr: got %h exp 0", bus.ram_addr); end
  endtask

  task automatic test_sw_lw;
    logic e, ee, ab; int lat, el, wd, ew; logic [31:0] er;
    ref_apply(6'h2B, 32'h08, 32'hDEADBEEF, ee, el, ew, er);
    do_op(6'h2B, 32'h08, 32'hDEADBEEF, lat, e, ab, wd);
    checks++; if (lat !== 1) begin errors++; $display("FAIL sw_latency: got %0d exp 1", lat); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL sw_err: got %b exp 0", e); end
    checks++; if (wd !== 1) begin errors++; $display("FAIL sw_writes: got %0d exp 1", wd); end
    checks++; if (snap_we[0] !== 1'b1 || snap_wd[0] !== 32'hDEADBEEF || snap_ad[0] !== 32'h08) begin
      errors++; $display("FAIL sw_ram_bus: got we=%b data=%h addr=%h exp we=1 data=deadbeef addr=00000008", snap_we[0], snap_wd[0], snap_ad[0]);
    end
    ref_apply(6'h23, 32'h08, 32'h0, ee, el, ew, er);
    do_op(6'h23, 32'h08, 32'h0, lat, e, ab, wd);
    checks++; if (bus.rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_rdata: got %h exp deadbeef", bus.rdata); end
    checks++; if (lat !== 1 || e !== 1'b0) begin errors++; $display("FAIL lw_done: got lat=%0d err=%b exp lat=1 err=0", lat, e); end
  endtask

  task automatic test_sb_rmw;
    logic e, ee, ab; int lat, el, wd, ew; logic [31:0] er;
    ref_apply(6'h28, 32'h09, 32'h000000AA, ee, el, ew, er);
    do_op(6'h28, 32'h09, 32'h000000AA, lat, e, ab, wd);
    checks++; if (lat !== 2) begin errors++; $display("FAIL sb_latency: got %0d exp 2", lat); end
    checks++; if (snap_we[0] !== 1'b0) begin errors++; $display("FAIL sb_read_cycle_we: got %b exp 0", snap_we[0]); end
    checks++; if (snap_we[1] !== 1'b1 || snap_wd[1] !== 32'hDEADAAEF || snap_ad[1] !== 32'h08) begin
      errors++; $display("FAIL sb_write_cycle: got we=%b data=%h addr=%h exp we=1 data=deadaaef addr=00000008", snap_we[1], snap_wd[1], snap_ad[1]);
    end
    checks++; if (wd !== 1 || e !== 1'b0) begin errors++; $display("FAIL sb_writes: got %0d err=%b exp 1 err=0", wd, e); end
    ref_apply(6'h20, 32'h09, 32'h0, ee, el, ew, er);
    do_op(6'h20, 32'h09, 32'h0, lat, e, ab, wd);
    checks++; if (bus.rdata !== 32'hFFFFFFAA) begin errors++; $display("FAIL lb_rdata: got %h exp ffffffaa", bus.rdata); end
    ref_apply(6'h24, 32'h09, 32'h0, ee, el, ew, er);
    do_op(6'h24, 32'h09, 32'h0, lat, e, ab, wd);
    checks++; if (bus.rdata !== 32'h000000AA) begin errors++; $display("FAIL lbu_rdata: got %h exp 000000aa", bus.rdata); end
  endtask

  task automatic test_sh_loads;
    logic e, ee, ab; int lat, el, wd, ew; logic [31:0] er;
    ref_apply(6'h29, 32'h0A, 32'h00009234, ee, el, ew, er);
    do_op(6'h29, 32'h0A, 32'h00009234, lat, e, ab, wd);
    checks++; if (lat !== 2 || snap_we[1] !== 1'b1 || snap_wd[1] !== 32'h9234AAEF) begin
      errors++; $display("FAIL sh_write: got lat=%0d we=%b data=%h exp lat=2 we=1 data=9234aaef", lat, snap_we[1], snap_wd[1]);
    end
    ref_apply(6'h21, 32'h0A, 32'h0, ee, el, ew, er);
    do_op(6'h21, 32'h0A, 32'h0, lat, e, ab, wd);
    checks++; if (bus.rdata !== 32'hFFFF9234) begin errors++; $display("FAIL lh_rdata: got %h exp ffff9234", bus.rdata); end
    ref_apply(6'h25, 32'h0A, 32'h0, ee, el, ew, er);
    do_op(6'h25, 32'h0A, 32'h0, lat, e, ab, wd);
    checks++; if (bus.rdata !== 32'h00009234) begin errors++; $display("FAIL lhu_rdata: got %h exp 00009234", bus.rdata); end
  endtask

  task automatic test_misaligned;
    logic e, ee, ab; int lat, el, wd, ew; logic [31:0] er;
    ref_apply(6'h23, 32'h06, 32'h0, ee, el, ew, er);
    do_op(6'h23, 32'h06, 32'h0, lat, e, ab, wd);
    checks++; if (lat !== 1 || e !== 1'b1) begin errors++; $display("FAIL misaligned_done: got lat=%0d err=%b exp lat=1 err=1", lat, e); end
    checks++; if (wd !== 0 || snap_we[0] !== 1'b0) begin errors++; $display("FAIL misaligned_write: got writes=%0d we=%b exp 0", wd, snap_we[0]); end
    checks++; if (bus.rdata !== 32'h00009234) begin errors++; $display("FAIL misaligned_rdata: got %h exp 00009234", bus.rdata); end
  endtask

  task automatic test_reset_in_merge;
    logic e, ee, ab; int lat, el, wd, ew; logic [31:0] er, old;
    int w0; bit saw_done;
    old = {ref_mem[19], ref_mem[18], ref_mem[17], ref_mem[16]};
    w0 = wr_count;
    bus.req = 1'b1; bus.op = 6'h28; bus.addr = 32'h11; bus.wdata = 32'h00000055;
    @(posedge clk);
    #1 bus.req = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL rst_merge_we: got %b exp 0", bus.ram_we); end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    ref_rdata = 32'h0;
    test_reset();
    checks++; if (wr_count !== w0) begin errors++; $display("FAIL rst_merge_writes: got %0d exp %0d", wr_count, w0); end
    saw_done = 1'b0;
    repeat (3) begin @(negedge clk); if (bus.done) saw_done = 1'b1; end
    checks++; if (saw_done) begin errors++; $display("FAIL rst_merge_done: got 1 exp 0"); end
    ref_apply(6'h23, 32'h10, 32'h0, ee, el, ew, er);
    do_op(6'h23, 32'h10, 32'h0, lat, e, ab, wd);
    checks++; if (bus.rdata !== old || e !== 1'b0) begin errors++; $display("FAIL rst_merge_old_word: got %h err=%b exp %h err=0", bus.rdata, e, old); end
  endtask

  task automatic test_handshake;
    logic e, ee, ab; int lat, el, wd, ew; logic [31:0] er, d;
    int w0; int n; bit got;
    d = $urandom;
    w0 = wr_count;
    ref_apply(6'h28, 32'h21, d, ee, el, ew, er);
    bus.req = 1'b1; bus.op = 6'h28; bus.addr = 32'h21; bus.wdata = d;
    @(posedge clk);
    n = 0; got = 1'b0;
    while (n < 8) begin
      @(negedge clk);
      n++;
      if (bus.done) begin got = 1'b1; break; end
    end
    bus.req = 1'b0;
    checks++; if (!got || n !== 3) begin errors++; $display("FAIL held_req_done: got seen=%b cycles=%0d exp seen=1 cycles=3", got, n); end
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || (wr_count - w0) !== 1) begin
      errors++; $display("FAIL held_req_single: got busy=%b writes=%0d exp busy=0 writes=1", bus.busy, wr_count - w0);
    end
    // Back-to-back: each do_op presents its request in the previous done cycle.
    d = $urandom;
    ref_apply(6'h2B, 32'h30, d, ee, el, ew, er);
    do_op(6'h2B, 32'h30, d, lat, e, ab, wd);
    ref_apply(6'h23, 32'h30, 32'h0, ee, el, ew, er);
    do_op(6'h23, 32'h30, 32'h0, lat, e, ab, wd);
    checks++; if (ab !== 1'b1 || lat !== 1) begin errors++; $display("FAIL b2b_accept: got busy=%b lat=%0d exp busy=1 lat=1", ab, lat); end
    checks++; if (bus.rdata !== d) begin errors++; $display("FAIL b2b_rdata: got %h exp %h", bus.rdata, d); end
  endtask

  task automatic test_random;
    logic [5:0] ops [0:10];
    logic [5:0] o; logic [31:0] a, d, er;
    logic e, ee, ab; int lat, el, wd, ew, sz;
    ops = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B, 6'h00, 6'h22, 6'h3F};
    for (int k = 0; k < 150; k++) begin
      o  = ops[$urandom_range(0, 10)];
      a  = 32'($urandom_range(0, 63));
      d  = $urandom;
      sz = op_size(o);
      if (sz > 1 && $urandom_range(0, 3) != 0) a[1:0] = (sz == 4) ? 2'b00 : {a[1], 1'b0};
      ref_apply(o, a, d, ee, el, ew, er);
      do_op(o, a, d, lat, e, ab, wd);
      checks++; if (e !== ee || lat !== el) begin errors++; $display("FAIL rand_done op=%h addr=%h: got err=%b lat=%0d exp err=%b lat=%0d", o, a, e, lat, ee, el); end
      checks++; if (wd !== ew) begin errors++; $display("FAIL rand_writes op=%h addr=%h: got %0d exp %0d", o, a, wd, ew); end
      checks++; if (bus.rdata !== er) begin errors++; $display("FAIL rand_rdata op=%h addr=%h: got %h exp %h", o, a, bus.rdata, er); end
    end
  endtask

  initial begin
    checks = 0; errors = 0; wr_count = 0;
    rst = 1'b1; load_ram = 1'b1; ref_rdata = 32'h0;
    bus.req = 1'b0; bus.op = 6'h0; bus.addr = 32'h0; bus.wdata = 32'h0;
    for (int i = 0; i < 16; i++) begin
      init_val[i] = $urandom;
      for (int j = 0; j < 4; j++) ref_mem[4*i + j] = init_val[i][8*j +: 8];
    end
    repeat (3) @(posedge clk);
    #1 load_ram = 1'b0;
    @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_sw_lw();
    test_sb_rmw();
    test_sh_loads();
    test_misaligned();
    test_reset_in_merge();
    test_handshake();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
